sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 141 ++++++++++++++
 tb/tb_sram_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Tile-map SRAM arbiter: video reads, game reads/writes and a full-map clear
// share one single-port RAM. Video normally wins, but a game request denied
// for STARVE_MAX cycles overrides video for one access.
module sram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 3,
    parameter int unsigned DEPTH      = 4800,
    parameter int unsigned CLEAR_VAL  = 0,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_vid_req,
    input  logic [ADDR_WIDTH-1:0] i_vid_addr,
    output logic                  o_vid_valid,
    output logic [DATA_WIDTH-1:0] o_vid_data,
    output logic                  o_vid_miss,
    input  logic                  i_gm_req,
    input  logic                  i_gm_we,
    input  logic [ADDR_WIDTH-1:0] i_gm_addr,
    input  logic [DATA_WIDTH-1:0] i_gm_wdata,
    output logic                  o_gm_ack,
    output logic                  o_gm_rvalid,
    output logic [DATA_WIDTH-1:0] o_gm_rdata,
    input  logic                  i_clr_start,
    output logic                  o_clr_busy,
    output logic                  o_clr_done,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic                  o_ram_write,
    output logic [DATA_WIDTH-1:0] o_ram_data,
    input  logic [DATA_WIDTH-1:0] i_ram_data
);

    localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_WIDTH-1:0] LastAddr    = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0] ClearData   = DATA_WIDTH'(CLEAR_VAL);
    localparam logic [StarveW-1:0]    StarveLimit = StarveW'(STARVE_MAX);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   clr_addr_q;
    logic [StarveW-1:0]      starve_q;
    logic                    vid_valid_q;
    logic                    vid_miss_q;
    logic                    gm_rvalid_q;
    logic                    clr_busy_q;
    logic                    clr_done_q;

    logic starved;
    logic gm_grant;
    logic vid_grant;
    logic vid_drop;

    // Grant decision: starved game > video > game, nothing granted while clearing.
    always_comb begin
        starved   = 1'b0;
        gm_grant  = 1'b0;
        vid_grant = 1'b0;
        vid_drop  = 1'b0;
        if (state_q == StIdle) begin
            starved   = i_gm_req && (starve_q == StarveLimit);
            vid_grant = i_vid_req && !starved;
            vid_drop  = i_vid_req && starved;
            gm_grant  = i_gm_req && (starved || !i_vid_req);
        end
    end

    // RAM port mux: exactly one requester drives the RAM each cycle.
    always_comb begin
        o_ram_addr  = '0;
        o_ram_write = 1'b0;
        o_ram_data  = '0;
        if (state_q == StClear) begin
            o_ram_addr  = clr_addr_q;
            o_ram_write = 1'b1;
            o_ram_data  = ClearData;
        end else if (gm_grant) begin
            o_ram_addr  = i_gm_addr;
            o_ram_write = i_gm_we;
            o_ram_data  = i_gm_wdata;
        end else if (vid_grant) begin
            o_ram_addr  = i_vid_addr;
        end
    end

    // State machine, counters and registered status flags.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= StIdle;
            clr_addr_q  <= '0;
            starve_q    <= '0;
            vid_valid_q <= 1'b0;
            vid_miss_q  <= 1'b0;
            gm_rvalid_q <= 1'b0;
            clr_busy_q  <= 1'b0;
            clr_done_q  <= 1'b0;
        end else begin
            vid_valid_q <= vid_grant;
            vid_miss_q  <= vid_drop;
            gm_rvalid_q <= gm_grant && !i_gm_we;
            clr_done_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (gm_grant) begin
                        starve_q <= '0;
                    end else if (i_gm_req && (starve_q != StarveLimit)) begin
                        starve_q <= starve_q + 1'b1;
                    end
                    if (i_clr_start) begin
                        state_q    <= StClear;
                        clr_addr_q <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                StClear: begin
                    // i_clr_start is deliberately ignored here: no restart.
                    if (clr_addr_q == LastAddr) begin
                        state_q    <= StIdle;
                        clr_busy_q <= 1'b0;
                        clr_done_q <= 1'b1;
                    end else begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // The RAM's own output register supplies the one-cycle read latency, so
    // read data is forwarded (zeroed when not valid) rather than re-registered.
    assign o_vid_data  = vid_valid_q ? i_ram_data : '0;
    assign o_gm_rdata  = gm_rvalid_q ? i_ram_data : '0;
    assign o_vid_valid = vid_valid_q;
    assign o_vid_miss  = vid_miss_q;
    assign o_gm_ack    = gm_grant;
    assign o_gm_rvalid = gm_rvalid_q;
    assign o_clr_busy  = clr_busy_q;
    assign o_clr_done  = clr_done_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: a RAM model on the RAM port, a
// behavioural reference model checked every cycle, plus directed scenarios.
module tb_sram_arbiter;

    localparam int AW    = 13;
    localparam int DW    = 3;
    localparam int DEPTH = 4800;
    localparam int SMAX  = 4;

    logic          i_clk = 1'b0;
    logic          i_rstn = 1'b1;
    logic          i_vid_req = 1'b0;
    logic [AW-1:0] i_vid_addr = '0;
    logic          o_vid_valid;
    logic [DW-1:0] o_vid_data;
    logic          o_vid_miss;
    logic          i_gm_req = 1'b0;
    logic          i_gm_we = 1'b0;
    logic [AW-1:0] i_gm_addr = '0;
    logic [DW-1:0] i_gm_wdata = '0;
    logic          o_gm_ack;
    logic          o_gm_rvalid;
    logic [DW-1:0] o_gm_rdata;
    logic          i_clr_start = 1'b0;
    logic          o_clr_busy;
    logic          o_clr_done;
    logic [AW-1:0] o_ram_addr;
    logic          o_ram_write;
    logic [DW-1:0] o_ram_data;
    logic [DW-1:0] ram_rd;
    logic          ram_init = 1'b1;

    sram_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .CLEAR_VAL (0),
        .STARVE_MAX(SMAX)
    ) dut (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_vid_req  (i_vid_req),
        .i_vid_addr (i_vid_addr),
        .o_vid_valid(o_vid_valid),
        .o_vid_data (o_vid_data),
        .o_vid_miss (o_vid_miss),
        .i_gm_req   (i_gm_req),
        .i_gm_we    (i_gm_we),
        .i_gm_addr  (i_gm_addr),
        .i_gm_wdata (i_gm_wdata),
        .o_gm_ack   (o_gm_ack),
        .o_gm_rvalid(o_gm_rvalid),
        .o_gm_rdata (o_gm_rdata),
        .i_clr_start(i_clr_start),
        .o_clr_busy (o_clr_busy),
        .o_clr_done (o_clr_done),
        .o_ram_addr (o_ram_addr),
        .o_ram_write(o_ram_write),
        .o_ram_data (o_ram_data),
        .i_ram_data (ram_rd)
    );

    always #5 i_clk = ~i_clk;

    // Initial RAM content before any write.
    function automatic logic [DW-1:0] pat(input int a);
        return DW'((a * 3 + 1) % 8);
    endfunction

    // Environment RAM: registered read, read data held on write cycles.
    logic [DW-1:0] mem [DEPTH];
    logic          wr  [DEPTH];
    always @(posedge i_clk) begin
        if (ram_init) begin
            for (int i = 0; i < DEPTH; i++) wr[i] <= 1'b0;
        end else if (o_ram_write) begin
            mem[o_ram_addr] <= o_ram_data;
            wr[o_ram_addr]  <= 1'b1;
        end else begin
            ram_rd <= wr[o_ram_addr] ? mem[o_ram_addr] : pat(int'(o_ram_addr));
        end
    end

    function automatic int env_rd(input int a);
        return wr[a] ? int'(mem[a]) : int'(pat(a));
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state: what the map holds and what the arbiter owes.
    logic [DW-1:0] m_mem [DEPTH];
    bit m_clr;
    int m_idx, m_wait;
    bit e_vv, e_vm, e_gv, e_busy, e_done;
    int e_vd, e_gd;

    task automatic model_reset();
        m_clr = 0; m_idx = 0; m_wait = 0;
        e_vv = 0; e_vm = 0; e_gv = 0; e_busy = 0; e_done = 0; e_vd = 0; e_gd = 0;
    endtask

    // One cycle of the reference model, evaluated mid-cycle with inputs stable.
    task automatic model_cycle();
        bit vid_g, gm_g, drop;
        int x_addr, x_we;
        if (!i_rstn) begin
            model_reset();
            chk("m_rst_vid_valid", int'(o_vid_valid), 0);
            chk("m_rst_vid_miss", int'(o_vid_miss), 0);
            chk("m_rst_gm_rvalid", int'(o_gm_rvalid), 0);
            chk("m_rst_busy", int'(o_clr_busy), 0);
            chk("m_rst_done", int'(o_clr_done), 0);
            chk("m_rst_vid_data", int'(o_vid_data), 0);
            chk("m_rst_gm_rdata", int'(o_gm_rdata), 0);
            return;
        end
        chk("m_vid_valid", int'(o_vid_valid), int'(e_vv));
        chk("m_vid_miss", int'(o_vid_miss), int'(e_vm));
        chk("m_gm_rvalid", int'(o_gm_rvalid), int'(e_gv));
        chk("m_clr_busy", int'(o_clr_busy), int'(e_busy));
        chk("m_clr_done", int'(o_clr_done), int'(e_done));
        if (e_vv) chk("m_vid_data", int'(o_vid_data), e_vd);
        if (e_gv) chk("m_gm_rdata", int'(o_gm_rdata), e_gd);

        vid_g = 0; gm_g = 0; drop = 0;
        if (m_clr) begin
            chk("m_clr_addr", int'(o_ram_addr), m_idx);
            chk("m_clr_write", int'(o_ram_write), 1);
            chk("m_clr_data", int'(o_ram_data), 0);
            chk("m_clr_ack", int'(o_gm_ack), 0);
            m_mem[m_idx] = '0;
            e_vv = 0; e_vm = 0; e_gv = 0;
            if (m_idx == DEPTH - 1) begin
                m_clr = 0; e_busy = 0; e_done = 1;
            end else begin
                m_idx++; e_busy = 1; e_done = 0;
            end
        end else begin
            if (i_gm_req && m_wait >= SMAX) begin
                gm_g = 1; drop = i_vid_req;
            end else if (i_vid_req) begin
                vid_g = 1;
            end else if (i_gm_req) begin
                gm_g = 1;
            end
            x_addr = gm_g ? int'(i_gm_addr) : (vid_g ? int'(i_vid_addr) : 0);
            x_we = (gm_g && i_gm_we) ? 1 : 0;
            chk("m_ram_addr", int'(o_ram_addr), x_addr);
            chk("m_ram_write", int'(o_ram_write), x_we);
            if (x_we == 1) chk("m_ram_data", int'(o_ram_data), int'(i_gm_wdata));
            chk("m_gm_ack", int'(o_gm_ack), int'(gm_g));
            e_vv = vid_g; e_vm = drop; e_gv = gm_g && !i_gm_we;
            e_vd = int'(m_mem[i_vid_addr]);
            e_gd = int'(m_mem[i_gm_addr]);
            if (x_we == 1) m_mem[x_addr] = i_gm_wdata;
            if (gm_g) m_wait = 0;
            else if (i_gm_req) m_wait = (m_wait + 1 > SMAX) ? SMAX : m_wait + 1;
            e_done = 0;
            if (i_clr_start) begin
                m_clr = 1; m_idx = 0; e_busy = 1;
            end else begin
                e_busy = 0;
            end
        end
    endtask

    // Check mid-cycle, then advance to just after the next rising edge.
    task automatic step();
        @(negedge i_clk);
        model_cycle();
        @(posedge i_clk);
        #1;
    endtask

    logic [DW-1:0] snap [DEPTH];

    initial begin
        int ack_cyc, miss_cnt, miss_cyc, busy_cnt, done_cnt, bad_cnt, busy_bad, acks;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = pat(i);
        model_reset();
        #1 i_rstn = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_vid_valid", int'(o_vid_valid), 0);
        chk("rst_gm_rvalid", int'(o_gm_rvalid), 0);
        chk("rst_clr_busy", int'(o_clr_busy), 0);
        chk("rst_ram_write", int'(o_ram_write), 0);
        chk("rst_ram_addr", int'(o_ram_addr), 0);
        ram_init = 1'b0;
        i_rstn = 1'b1;
        step();

        // Video only: addresses 0..9 back to back.
        i_vid_req = 1'b1;
        for (int a = 0; a < 10; a++) begin
            i_vid_addr = AW'(a);
            step();
            chk("v_valid", int'(o_vid_valid), 1);
            chk("v_data", int'(o_vid_data), int'(pat(a)));
            if (a == 2) chk("v_data_addr2", int'(o_vid_data), 7);
        end
        i_vid_req = 1'b0;
        step();
        chk("v_valid_end", int'(o_vid_valid), 0);

        // Game write then read of 2025.
        i_gm_req = 1'b1; i_gm_we = 1'b1; i_gm_addr = 13'd2025; i_gm_wdata = 3'd4;
        #1;
        chk("g_wr_ack", int'(o_gm_ack), 1);
        chk("g_wr_ram_write", int'(o_ram_write), 1);
        step();
        chk("g_wr_no_rvalid", int'(o_gm_rvalid), 0);
        i_gm_we = 1'b0;
        #1;
        chk("g_rd_ack", int'(o_gm_ack), 1);
        step();
        i_gm_req = 1'b0;
        chk("g_rd_rvalid", int'(o_gm_rvalid), 1);
        chk("g_rd_rdata", int'(o_gm_rdata), 4);

        // Contention: game must win on its 5th requesting cycle.
        ack_cyc = 0; miss_cnt = 0; miss_cyc = 0;
        i_vid_req = 1'b1; i_gm_req = 1'b1; i_gm_we = 1'b0; i_gm_addr = 13'd7;
        for (int c = 1; c <= 10; c++) begin
            i_vid_addr = AW'(c);
            #1;
            if (o_gm_ack && ack_cyc == 0) ack_cyc = c;
            step();
            if (ack_cyc == c) i_gm_req = 1'b0;
            if (o_vid_miss) begin
                miss_cnt++; miss_cyc = c + 1;
                chk("s_miss_no_valid", int'(o_vid_valid), 0);
            end
        end
        i_vid_req = 1'b0;
        chk("s_ack_cycle", ack_cyc, 5);
        chk("s_miss_count", miss_cnt, 1);
        chk("s_miss_cycle", miss_cyc, 6);

        // Reset while clearing address 1000: abort, upper entries untouched.
        for (int i = 0; i < DEPTH; i++) snap[i] = DW'(env_rd(i));
        i_clr_start = 1'b1;
        step();
        i_clr_start = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (o_clr_busy && int'(o_ram_addr) == 1000) break;
            step();
        end
        chk("r_reached_1000", int'(o_ram_addr), 1000);
        i_rstn = 1'b0;
        #1;
        chk("r_vid_valid", int'(o_vid_valid), 0);
        chk("r_vid_miss", int'(o_vid_miss), 0);
        chk("r_gm_rvalid", int'(o_gm_rvalid), 0);
        chk("r_busy", int'(o_clr_busy), 0);
        chk("r_done", int'(o_clr_done), 0);
        chk("r_ram_write", int'(o_ram_write), 0);
        step();
        step();
        i_rstn = 1'b1;
        done_cnt = 0;
        repeat (5) begin
            step();
            if (o_clr_done) done_cnt++;
        end
        chk("r_no_done", done_cnt, 0);
        bad_cnt = 0;
        for (int i = 0; i < 1000; i++) if (env_rd(i) != 0) bad_cnt++;
        chk("r_low_cleared", bad_cnt, 0);
        bad_cnt = 0;
        for (int i = 1000; i < DEPTH; i++) if (env_rd(i) != int'(snap[i])) bad_cnt++;
        chk("r_high_kept", bad_cnt, 0);

        // Full clear with both masters requesting.
        i_vid_req = 1'b1; i_vid_addr = 13'd5;
        i_gm_req = 1'b1; i_gm_we = 1'b0; i_gm_addr = 13'd3;
        i_clr_start = 1'b1;
        step();
        i_clr_start = 1'b0;
        busy_cnt = o_clr_busy ? 1 : 0;
        done_cnt = 0; busy_bad = 0; acks = 0;
        for (int k = 0; k < 5000 && o_clr_busy; k++) begin
            if (o_gm_ack) acks++;
            step();
            if (o_clr_busy) busy_cnt++;
            if (o_clr_done) done_cnt++;
            if (o_clr_busy && (o_vid_valid || o_gm_rvalid || o_vid_miss)) busy_bad++;
        end
        i_vid_req = 1'b0; i_gm_req = 1'b0;
        step();
        if (o_clr_done) done_cnt++;
        chk("c_busy_cycles", busy_cnt, 4800);
        chk("c_done_pulses", done_cnt, 1);
        chk("c_acks_in_clear", acks, 0);
        chk("c_valids_in_clear", busy_bad, 0);
        bad_cnt = 0;
        for (int i = 0; i < DEPTH; i++) if (env_rd(i) != 0) bad_cnt++;
        chk("c_all_zero", bad_cnt, 0);

        // Clear re-pulsed at address 10 must not extend the sequence.
        i_gm_req = 1'b1; i_gm_we = 1'b1; i_gm_addr = 13'd4799; i_gm_wdata = 3'd5;
        step();
        i_gm_req = 1'b0; i_gm_we = 1'b0;
        chk("p_pre_write", env_rd(4799), 5);
        i_clr_start = 1'b1;
        step();
        i_clr_start = 1'b0;
        busy_cnt = o_clr_busy ? 1 : 0;
        for (int k = 0; k < 5000 && o_clr_busy; k++) begin
            i_clr_start = (int'(o_ram_addr) == 10) ? 1'b1 : 1'b0;
            step();
            if (o_clr_busy) busy_cnt++;
        end
        i_clr_start = 1'b0;
        chk("p_done_now", int'(o_clr_done), 1);
        step();
        chk("p_busy_cycles", busy_cnt, 4800);
        chk("p_last_cleared", env_rd(4799), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
